// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
//   Shared definitions for the maze movement controller:
//   - default grid dimensions and the cell-coordinate width
//   - direction and controller-state enums
//   - pending-move record and target-cell record
//   - next_cell(): one-step neighbour of a cell plus an in-bounds flag
// -----------------------------------------------------------------------------
package maze_pkg;

  localparam int GRID_W_DEF = 32;  // 640 px / 20 px cells
  localparam int GRID_H_DEF = 24;  // 480 px / 20 px cells
  localparam int COORD_W    = 5;   // enough for 0..31

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_WON    = 2'd3
  } state_e;

  // One buffered move: direction plus occupancy flag.
  typedef struct packed {
    logic valid;
    dir_e dir;
  } pending_t;

  // Neighbour cell and whether it lies inside the grid.
  typedef struct packed {
    logic   ok;
    coord_t x;
    coord_t y;
  } cell_t;

  // Step one cell from (x,y) in direction dir. The wrapped coordinate
  // produced at an edge is harmless because ok is cleared there.
  function automatic cell_t next_cell(input coord_t x,
                                      input coord_t y,
                                      input dir_e   dir,
                                      input int     gw,
                                      input int     gh);
    cell_t c;
    c.ok = 1'b1;
    c.x  = x;
    c.y  = y;
    unique case (dir)
      DIR_UP: begin
        c.ok = (y != '0);
        c.y  = y - COORD_W'(1);
      end
      DIR_DOWN: begin
        c.ok = (int'(y) < gh - 1);
        c.y  = y + COORD_W'(1);
      end
      DIR_LEFT: begin
        c.ok = (x != '0);
        c.x  = x - COORD_W'(1);
      end
      DIR_RIGHT: begin
        c.ok = (int'(x) < gw - 1);
        c.x  = x + COORD_W'(1);
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
//   Brings one raw active-low pushbutton into the clock domain with a 2-flop
//   synchronizer and emits a one-cycle pulse on each synchronized 1->0
//   transition (the moment the button goes down).
//
// Ports
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   btn_n  in  1  raw button, active-low, asynchronous to clk
//   press  out 1  one-cycle pulse per press
// -----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic meta;   // first stage, may go metastable
  logic sync;   // second stage, safe to use
  logic prev;   // sync delayed one cycle, for edge detection

  // NOTE: all three flops reset to 1 (button released) so that releasing
  // reset while a button is held does not fabricate a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three stages shift together;
      // blocking ones here would collapse the chain into a single flop.
      meta <= btn_n;
      sync <= meta;
      prev <= sync;
    end
  end

  // Built only from flop outputs, so the pulse is clean and one cycle wide.
  assign press = prev & ~sync;

endmodule

// File: rtl/maze_move_ctrl.sv
// -----------------------------------------------------------------------------
// maze_move_ctrl
//   Player movement controller for a grid maze. Button presses are buffered
//   as a single pending move; on each frame tick in IDLE the pending move is
//   bounds-checked, then the wall map is queried for the target cell. An
//   open cell is committed to the position register; reaching the goal cell
//   locks the controller in WON until reset.
//
// Ports
//   iCLK         in   1   clock, rising edge
//   iRST_N       in   1   asynchronous active-low reset
//   iBTN_N       in   4   raw buttons, active-low: [0]up [1]down [2]left [3]right
//   iFRAME_TICK  in   1   one-cycle pulse at start of vertical blank
//   oMAP_REQ     out  1   wall-map read request (high only in CHECK)
//   oMAP_X       out  5   wall-map cell x address
//   oMAP_Y       out  5   wall-map cell y address
//   iMAP_ACK     in   1   one-cycle acknowledge, iMAP_WALL valid with it
//   iMAP_WALL    in   1   1 = addressed cell is a wall
//   oPOS_X       out  5   player cell x
//   oPOS_Y       out  5   player cell y
//   oMOVES       out  10  committed-move count, saturating at 1023
//   oWIN         out  1   player has reached the goal (level)
//   oBUSY        out  1   controller is in any state other than IDLE
// -----------------------------------------------------------------------------
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int GOAL_X      = 30,
  parameter int GOAL_Y      = 22,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [3:0]         iBTN_N,
  input  logic               iFRAME_TICK,
  output logic               oMAP_REQ,
  output logic [COORD_W-1:0] oMAP_X,
  output logic [COORD_W-1:0] oMAP_Y,
  input  logic               iMAP_ACK,
  input  logic               iMAP_WALL,
  output logic [COORD_W-1:0] oPOS_X,
  output logic [COORD_W-1:0] oPOS_Y,
  output logic [9:0]         oMOVES,
  output logic               oWIN,
  output logic               oBUSY
);

  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  // Counter value on the last CHECK cycle before giving up, so the request
  // is held for exactly ACK_TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  localparam coord_t START_XC = COORD_W'(START_X);
  localparam coord_t START_YC = COORD_W'(START_Y);
  localparam coord_t GOAL_XC  = COORD_W'(GOAL_X);
  localparam coord_t GOAL_YC  = COORD_W'(GOAL_Y);

  // ---------------------------------------------------------------------------
  // Button synchronizers, one per direction
  // ---------------------------------------------------------------------------
  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_sync_edge u_sync (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .btn_n (iBTN_N[i]),
      .press (press[i])
    );
  end

  // Simultaneous presses collapse to one direction: up > down > left > right.
  logic press_any;
  dir_e press_dir;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    press_any = |press;
    press_dir = DIR_UP;
    if (press[0])      press_dir = DIR_UP;
    else if (press[1]) press_dir = DIR_DOWN;
    else if (press[2]) press_dir = DIR_LEFT;
    else if (press[3]) press_dir = DIR_RIGHT;
  end

  // ---------------------------------------------------------------------------
  // Controller state and registered outputs
  // ---------------------------------------------------------------------------
  state_e          state;
  pending_t        pend;
  logic [TO_W-1:0] to_cnt;
  coord_t          pos_x;
  coord_t          pos_y;
  coord_t          map_x;
  coord_t          map_y;
  logic            map_req;
  logic [9:0]      moves;
  logic            win;
  logic            busy;

  // Target cell of the pending move from the current position.
  cell_t tgt;
  assign tgt = next_cell(pos_x, pos_y, pend.dir, GRID_W, GRID_H);

  // A tick only matters in IDLE with something pending; it consumes the
  // pending move whether or not the move turns out to be in bounds.
  logic take_move;
  assign take_move = (state == ST_IDLE) && iFRAME_TICK && pend.valid;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= ST_IDLE;
      pend    <= '{valid: 1'b0, dir: DIR_UP};
      to_cnt  <= '0;
      pos_x   <= START_XC;
      pos_y   <= START_YC;
      map_x   <= '0;
      map_y   <= '0;
      map_req <= 1'b0;
      moves   <= '0;
      win     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // Out-of-grid targets are dropped here without touching the map.
          if (take_move && tgt.ok) begin
            state   <= ST_CHECK;
            map_req <= 1'b1;
            map_x   <= tgt.x;
            map_y   <= tgt.y;
            to_cnt  <= '0;
            busy    <= 1'b1;
          end
        end

        ST_CHECK: begin
          // map_x/map_y hold the target for the whole CHECK and COMMIT.
          if (iMAP_ACK) begin
            map_req <= 1'b0;
            if (iMAP_WALL) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_COMMIT;
            end
          end else if (to_cnt == TO_LAST) begin
            // Map never answered: treat the cell as a wall.
            map_req <= 1'b0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_COMMIT: begin
          pos_x <= map_x;
          pos_y <= map_y;
          if (moves != '1) moves <= moves + 10'd1;
          if (map_x == GOAL_XC && map_y == GOAL_YC) begin
            state <= ST_WON;
            win   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_WON: begin
          // Terminal until reset.
        end
      endcase

      // Pending-move buffer: consumed by an IDLE tick, otherwise filled by a
      // press only while empty. Presses are discarded once the game is won.
      if (take_move) begin
        pend.valid <= 1'b0;
      end else if (!pend.valid && press_any && state != ST_WON) begin
        pend.valid <= 1'b1;
        pend.dir   <= press_dir;
      end
    end
  end

  assign oMAP_REQ = map_req;
  assign oMAP_X   = map_x;
  assign oMAP_Y   = map_y;
  assign oPOS_X   = pos_x;
  assign oPOS_Y   = pos_y;
  assign oMOVES   = moves;
  assign oWIN     = win;
  assign oBUSY    = busy;

endmodule

// File: tb/tb_maze_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_move_ctrl
//   Directed testbench for maze_move_ctrl with default parameters.
//   Inputs are driven 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_maze_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_n;
  logic       frame_tick;
  logic       map_ack;
  logic       map_wall;
  logic       map_req;
  logic [4:0] map_x;
  logic [4:0] map_y;
  logic [4:0] pos_x;
  logic [4:0] pos_y;
  logic [9:0] moves;
  logic       win;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [3:0] B_UP    = 4'b0001;
  localparam logic [3:0] B_DOWN  = 4'b0010;
  localparam logic [3:0] B_LEFT  = 4'b0100;
  localparam logic [3:0] B_RIGHT = 4'b1000;

  always #5 clk = ~clk;

  maze_move_ctrl dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iBTN_N      (btn_n),
    .iFRAME_TICK (frame_tick),
    .oMAP_REQ    (map_req),
    .oMAP_X      (map_x),
    .oMAP_Y      (map_y),
    .iMAP_ACK    (map_ack),
    .iMAP_WALL   (map_wall),
    .oPOS_X      (pos_x),
    .oPOS_Y      (pos_y),
    .oMOVES      (moves),
    .oWIN        (win),
    .oBUSY       (busy)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold the buttons in mask down for 4 cycles, then release for 4 cycles.
  // The synchronizer plus edge detector loads the pending register on the
  // third edge after the press.
  task automatic do_press(input logic [3:0] mask);
    btn_n = ~mask;
    repeat (4) cyc();
    btn_n = 4'hF;
    repeat (4) cyc();
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic do_ack(input logic wall);
    map_ack  = 1'b1;
    map_wall = wall;
    cyc();
    map_ack  = 1'b0;
    map_wall = 1'b0;
  endtask

  // Full open-cell move: press, tick, immediate ack, commit cycle.
  task automatic do_move(input logic [3:0] mask);
    do_press(mask);
    do_tick();
    do_ack(1'b0);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    btn_n      = 4'hF;
    frame_tick = 1'b0;
    map_ack    = 1'b0;
    map_wall   = 1'b0;

    // ---- Reset state ----
    #12;
    check("rst_pos_x", pos_x, 1);
    check("rst_pos_y", pos_y, 1);
    check("rst_moves", moves, 0);
    check("rst_win",   win,   0);
    check("rst_req",   map_req, 0);
    check("rst_busy",  busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc();

    // ---- Right from (1,1), map answers open after 3 cycles ----
    do_press(B_RIGHT);
    do_tick();
    check("r1_req",  map_req, 1);
    check("r1_mx",   map_x, 2);
    check("r1_my",   map_y, 1);
    check("r1_busy", busy, 1);
    repeat (3) cyc();
    check("r1_req_held", map_req, 1);
    check("r1_mx_held",  map_x, 2);
    do_ack(1'b0);
    check("r1_req_drop", map_req, 0);
    check("r1_pos_pre",  pos_x, 1);
    cyc();
    check("r1_pos_x", pos_x, 2);
    check("r1_pos_y", pos_y, 1);
    check("r1_moves", moves, 1);
    check("r1_busy_idle", busy, 0);

    // ---- Up into a wall ----
    do_press(B_UP);
    do_tick();
    check("w_req", map_req, 1);
    check("w_mx",  map_x, 2);
    check("w_my",  map_y, 0);
    do_ack(1'b1);
    check("w_req_drop", map_req, 0);
    check("w_busy",     busy, 0);
    cyc();
    check("w_pos_x", pos_x, 2);
    check("w_pos_y", pos_y, 1);
    check("w_moves", moves, 1);

    // ---- Stray ack in IDLE is ignored ----
    do_ack(1'b0);
    cyc();
    check("stray_pos_x", pos_x, 2);
    check("stray_busy",  busy, 0);
    check("stray_moves", moves, 1);

    // ---- Walk to (0,5) ----
    do_move(B_LEFT);
    do_move(B_LEFT);
    repeat (4) do_move(B_DOWN);
    check("walk_pos_x", pos_x, 0);
    check("walk_pos_y", pos_y, 5);
    check("walk_moves", moves, 7);

    // ---- Left at x=0: rejected without a request ----
    do_press(B_LEFT);
    do_tick();
    check("edge_req",  map_req, 0);
    check("edge_busy", busy, 0);
    repeat (2) cyc();
    check("edge_req2", map_req, 0);
    check("edge_pos_x", pos_x, 0);

    // ---- Up and right together: up wins, right dropped ----
    do_press(B_UP | B_RIGHT);
    do_tick();
    check("pri_req", map_req, 1);
    check("pri_mx",  map_x, 0);
    check("pri_my",  map_y, 4);
    do_ack(1'b1);
    do_tick();
    check("pri_drop_req",  map_req, 0);
    check("pri_drop_busy", busy, 0);

    // ---- No ack: timeout after 255 cycles ----
    do_press(B_DOWN);
    do_tick();
    check("to_req", map_req, 1);
    check("to_my",  map_y, 6);
    repeat (254) cyc();
    check("to_req_254", map_req, 1);
    cyc();
    check("to_req_255", map_req, 0);
    check("to_busy",    busy, 0);
    check("to_pos_y",   pos_y, 5);
    check("to_moves",   moves, 7);

    // ---- Press during CHECK is latched and serviced at next tick ----
    do_press(B_DOWN);
    do_tick();
    do_press(B_RIGHT);
    check("lat_req_held", map_req, 1);
    check("lat_my",       map_y, 6);
    do_ack(1'b0);
    cyc();
    check("lat_pos_y", pos_y, 6);
    check("lat_moves", moves, 8);
    do_tick();
    check("lat_req2", map_req, 1);
    check("lat_mx2",  map_x, 1);
    check("lat_my2",  map_y, 6);
    do_ack(1'b1);

    // ---- Walk to (29,22) then step onto the goal ----
    repeat (16) do_move(B_DOWN);
    repeat (29) do_move(B_RIGHT);
    check("pre_goal_x", pos_x, 29);
    check("pre_goal_y", pos_y, 22);
    check("pre_goal_moves", moves, 53);
    check("pre_goal_win", win, 0);
    do_press(B_RIGHT);
    do_tick();
    check("goal_mx", map_x, 30);
    check("goal_my", map_y, 22);
    do_ack(1'b0);
    check("goal_win_pre", win, 0);
    cyc();
    check("goal_win",   win, 1);
    check("goal_pos_x", pos_x, 30);
    check("goal_moves", moves, 54);
    check("goal_busy",  busy, 1);

    // ---- WON is terminal ----
    do_press(B_UP);
    do_tick();
    check("won_req", map_req, 0);
    cyc();
    check("won_req2",  map_req, 0);
    check("won_win",   win, 1);
    check("won_pos_y", pos_y, 22);

    // ---- Reset, enter CHECK, reset again mid-CHECK ----
    rst_n = 1'b0;
    #1;
    check("rst2_win",   win, 0);
    check("rst2_pos_x", pos_x, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    do_press(B_RIGHT);
    do_tick();
    check("mid_req",  map_req, 1);
    check("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_pos_x", pos_x, 1);
    check("mid_pos_y", pos_y, 1);
    check("mid_win",   win, 0);
    check("mid_req0",  map_req, 0);
    check("mid_busy0", busy, 0);
    check("mid_moves", moves, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
